// File: rtl/wt_dcache_flush_ctrl.sv
// Flush / invalidate / enable sequencer for the write-through L1 data cache.
// Drains the write buffer and miss unit, then clears every index via the cacheline write port.
module wt_dcache_flush_ctrl #(
   parameter int unsigned IdxWidth = 8,
   parameter int unsigned SetAssoc = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic                flush_i,
   output logic                flush_ack_o,
   input  logic                wbuffer_empty_i,
   input  logic                miss_pend_i,
   output logic                cache_en_o,
   output logic                busy_o,
   output logic                inv_vld_o,
   input  logic                inv_gnt_i,
   output logic [IdxWidth-1:0] inv_idx_o,
   output logic [SetAssoc-1:0] inv_we_o,
   output logic [SetAssoc-1:0] inv_vld_bits_o
);

   typedef enum logic [2:0] {INIT, IDLE, DRAIN, INV, ACK} state_e;

   state_e              state_q, state_d;
   logic [IdxWidth-1:0] cnt_q, cnt_d;
   logic                cache_en_q, cache_en_d;
   logic                flush_q, flush_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cache_en_d = cache_en_q;
      flush_d    = flush_q;
      case (state_q)
         // INIT and INV share the walk; only the exit differs
         INIT, INV: begin
            if (inv_gnt_i) begin
               cnt_d = cnt_q + 1'b1;
               if (&cnt_q) begin
                  if (state_q == INIT) begin
                     state_d = IDLE;
                  end else if (flush_q) begin
                     state_d = ACK;
                  end else begin
                     cache_en_d = 1'b0;
                     state_d    = IDLE;
                  end
               end
            end
         end
         IDLE: begin
            if (flush_i) begin
               flush_d = 1'b1;
               state_d = DRAIN;
            end else if (enable_i && !cache_en_q) begin
               cache_en_d = 1'b1;
            end else if (!enable_i && cache_en_q) begin
               flush_d = 1'b0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (wbuffer_empty_i && !miss_pend_i) begin
               if (cache_en_q)   state_d = INV;
               else if (flush_q) state_d = ACK;
               else              state_d = IDLE;
            end
         end
         ACK: begin
            flush_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         cache_en_q <= 1'b0;
         flush_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cache_en_q <= cache_en_d;
         flush_q    <= flush_d;
      end
   end

   // Pure state decodes: no input reaches an output combinationally
   assign inv_vld_o      = (state_q == INIT) || (state_q == INV);
   assign inv_idx_o      = cnt_q;
   assign inv_we_o       = {SetAssoc{inv_vld_o}};
   assign inv_vld_bits_o = '0;
   assign flush_ack_o    = (state_q == ACK);
   assign busy_o         = (state_q != IDLE);
   assign cache_en_o     = cache_en_q;

endmodule
